// File: rtl/pdp8_mem_ctrl.sv
// PDP-8 main-memory stage: one CPU access per mem_load strobe, completed with a
// one-cycle mem_ready after WAIT_STATES extra cycles; side-band preload port.
module pdp8_mem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic              mem_load,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              overrun
);

  // state  | meaning
  // IDLE   | waiting for mem_load; preload writes allowed
  // WAIT   | access latched, wait counter running down
  // DONE   | array read/write performed, mem_ready follows on next edge
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              we_q,      we_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              ready_q,   ready_d;
  logic              overrun_q, overrun_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    overrun_d = overrun_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem_load) begin
          addr_d  = address;
          wdata_d = write_data;
          we_d    = write_enable;
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_DONE : S_WAIT;
          // CPU access takes priority; a colliding preload is lost
          if (ld_en) overrun_d = 1'b1;
        end else if (ld_en) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = ld_data;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DONE;
        if (mem_load || ld_en) overrun_d = 1'b1;
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
        if (we_q) mem_we  = 1'b1;
        else      rdata_d = mem[addr_q];
        if (mem_load || ld_en) overrun_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  // Array is never cleared; reset only blocks a pending write
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign read_data = rdata_q;
  assign mem_ready = ready_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdp8_mem_ctrl.sv
// Randomized and directed checks of pdp8_mem_ctrl against a word-array model;
// a second instance with zero wait states covers back-to-back reads.
module tb_pdp8_mem_ctrl;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [11:0] a_address, a_wdata, a_rdata, a_ld_addr, a_ld_data;
  logic        a_we, a_load, a_ready, a_busy, a_ld_en, a_overrun;
  logic [11:0] b_address, b_wdata, b_rdata, b_ld_addr, b_ld_data;
  logic        b_we, b_load, b_ready, b_busy, b_ld_en, b_overrun;

  pdp8_mem_ctrl #(.ADDR_W(12), .DATA_W(12), .WAIT_STATES(WS)) dut_a (
    .clk(clk), .rst(rst), .address(a_address), .write_data(a_wdata),
    .write_enable(a_we), .mem_load(a_load), .read_data(a_rdata),
    .mem_ready(a_ready), .busy(a_busy), .ld_en(a_ld_en), .ld_addr(a_ld_addr),
    .ld_data(a_ld_data), .overrun(a_overrun)
  );

  pdp8_mem_ctrl #(.ADDR_W(12), .DATA_W(12), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .address(b_address), .write_data(b_wdata),
    .write_enable(b_we), .mem_load(b_load), .read_data(b_rdata),
    .mem_ready(b_ready), .busy(b_busy), .ld_en(b_ld_en), .ld_addr(b_ld_addr),
    .ld_data(b_ld_data), .overrun(b_overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] model [4096];
  logic [11:0] last_rd;
  logic [11:0] bvals [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    last_rd = 12'd0;
  endtask

  task automatic preload_a(input logic [11:0] ad, input logic [11:0] d);
    a_ld_en = 1'b1; a_ld_addr = ad; a_ld_data = d;
    tick();
    a_ld_en = 1'b0;
    model[ad] = d;
  endtask

  // One CPU access; expects mem_ready exactly WS+1 edges after the strobe edge
  task automatic access_a(input string tag, input logic [11:0] ad,
                          input logic [11:0] wd, input logic we);
    int  lat;
    logic seen;
    a_address = ad; a_wdata = wd; a_we = we; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    a_address = 12'($urandom_range(0, 4095));
    a_wdata   = 12'($urandom_range(0, 4095));
    a_we      = 1'($urandom_range(0, 1));
    chk({tag, " busy"}, 32'(a_busy), 32'd1);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (a_ready) begin seen = 1'b1; lat = i; end
    end
    chk({tag, " latency"}, 32'(lat), 32'(WS + 1));
    if (we) model[ad] = wd;
    else    last_rd = model[ad];
    chk({tag, " rdata"}, 32'(a_rdata), 32'(last_rd));
    chk({tag, " idle at ready"}, 32'(a_busy), 32'd0);
    tick();
    chk({tag, " ready width"}, 32'(a_ready), 32'd0);
  endtask

  initial begin
    int pulses;
    logic seen;
    logic [11:0] t1, t2, pa, ra;

    rst = 1'b1;
    a_address = '0; a_wdata = '0; a_we = 1'b0; a_load = 1'b0;
    a_ld_en = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    b_address = '0; b_wdata = '0; b_we = 1'b0; b_load = 1'b0;
    b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;
    do_reset();

    chk("reset busy", 32'(a_busy), 32'd0);
    chk("reset ready", 32'(a_ready), 32'd0);
    chk("reset rdata", 32'(a_rdata), 32'd0);
    chk("reset overrun", 32'(a_overrun), 32'd0);

    // zero-wait-state instance: 8 reads, strobe every 2 cycles
    for (int i = 0; i < 8; i++) begin
      bvals[i] = 12'($urandom_range(0, 4095));
      b_ld_en = 1'b1; b_ld_addr = 12'(i); b_ld_data = bvals[i];
      tick();
    end
    b_ld_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      b_address = 12'(i); b_we = 1'b0; b_load = 1'b1;
      tick();
      b_load = 1'b0;
      tick();
      if (b_ready) pulses++;
      chk("ws0 rdata", 32'(b_rdata), 32'(bvals[i]));
    end
    tick();
    chk("ws0 pulses", 32'(pulses), 32'd8);
    chk("ws0 overrun", 32'(b_overrun), 32'd0);

    // preload then read 0o200
    preload_a(12'o0200, 12'o7001);
    chk("preload no ready", 32'(a_ready), 32'd0);
    access_a("read 0200", 12'o0200, 12'd0, 1'b0);

    // write then read top address; write must leave read_data alone
    access_a("write 7777", 12'o7777, 12'o5252, 1'b1);
    access_a("read 7777", 12'o7777, 12'd0, 1'b0);

    // randomized traffic on a preloaded window
    for (int i = 0; i < 64; i++) preload_a(12'(i), 12'($urandom_range(0, 4095)));
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [11:0] ad;
      op = int'($urandom_range(0, 2));
      ad = 12'($urandom_range(0, 63));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
      case (op)
        0: access_a("rand read", ad, 12'd0, 1'b0);
        1: access_a("rand write", ad, 12'($urandom_range(0, 4095)), 1'b1);
        default: preload_a(ad, 12'($urandom_range(0, 4095)));
      endcase
    end
    chk("rand overrun", 32'(a_overrun), 32'd0);

    // preload colliding with a CPU strobe is dropped
    ra = 12'($urandom_range(0, 31));
    pa = 12'($urandom_range(32, 63));
    a_address = ra; a_we = 1'b0; a_load = 1'b1;
    a_ld_en = 1'b1; a_ld_addr = pa; a_ld_data = ~model[pa];
    tick();
    a_load = 1'b0; a_ld_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (a_ready) seen = 1'b1;
    end
    chk("collide ready", 32'(seen), 32'd1);
    last_rd = model[ra];
    chk("collide rdata", 32'(a_rdata), 32'(last_rd));
    chk("collide overrun", 32'(a_overrun), 32'd1);
    tick();
    access_a("collide preload lost", pa, 12'd0, 1'b0);

    do_reset();
    chk("rst clears overrun", 32'(a_overrun), 32'd0);

    // second strobe while busy is ignored
    t1 = 12'd5; t2 = 12'd6;
    a_address = t1; a_we = 1'b0; a_load = 1'b1;
    tick();
    a_address = t2; a_we = 1'b1; a_wdata = ~model[t2];
    tick();
    a_load = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (a_ready) pulses++;
    end
    chk("busy strobe pulses", 32'(pulses), 32'd1);
    chk("busy strobe overrun", 32'(a_overrun), 32'd1);
    last_rd = model[t1];
    chk("busy strobe rdata", 32'(a_rdata), 32'(last_rd));
    access_a("busy strobe target", t2, 12'd0, 1'b0);

    // reset during WAIT discards the write
    preload_a(12'o0010, 12'o0707);
    a_address = 12'o0010; a_wdata = 12'o1234; a_we = 1'b1; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_rd = 12'd0;
    chk("rst mid busy", 32'(a_busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_ready) seen = 1'b1;
    end
    chk("rst mid no ready", 32'(seen), 32'd0);
    chk("rst mid rdata", 32'(a_rdata), 32'd0);
    chk("rst mid overrun", 32'(a_overrun), 32'd0);
    access_a("rst mid old word", 12'o0010, 12'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
